// File: rtl/playfield_buffer.sv
// playfield_buffer: ROWS x COLS lock-piece playfield with full-row detection and collapse.
// Build macro PLAYFIELD_SHADOW_EN turns grid into a vblank-loaded, tear-free shadow copy.
module playfield_buffer #(
    parameter int ROWS = 20,
    parameter int COLS = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [COLS-1:0]           wr_mask,
    input  logic                      board_clear,
    input  logic                      vblank,
    output logic [ROWS*COLS-1:0]      grid,
    output logic                      done,
    output logic [$clog2(ROWS+1)-1:0] lines_cleared,
    output logic [15:0]               lines_total
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(ROWS + 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [COLS-1:0]   rows_q [ROWS];
    logic [COLS-1:0]   rows_d [ROWS];
    logic [ROW_W-1:0]  scan_row_q, scan_row_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       lines_total_q, lines_total_d;

    logic [ROWS-1:0]      row_full;
    logic [ROWS-1:0]      above_full;
    logic [16:0]          total_sum;
    logic [ROWS*COLS-1:0] array_flat;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_full[r] = &rows_q[r];
        end
    end

    // above_full[r] says whether the row that slides into r during a shift is full.
    assign above_full = {row_full[ROWS-2:0], 1'b0};
    assign total_sum  = {1'b0, lines_total_q} + 17'(count_q);

    assign wr_ready      = (state_q == S_IDLE) && !board_clear;
    assign done          = (state_q == S_DONE);
    assign lines_cleared = count_q;
    assign lines_total   = lines_total_q;

    // NOTE: every signal written here gets its default first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        rows_d        = rows_q;
        scan_row_d    = scan_row_q;
        count_d       = count_q;
        lines_total_d = lines_total_q;

        unique case (state_q)
            S_IDLE: begin
                if (board_clear) begin
                    for (int r = 0; r < ROWS; r++) begin
                        rows_d[r] = '0;
                    end
                    lines_total_d = '0;
                end else if (wr_valid) begin
                    // Out-of-range rows match nothing, so the array is untouched but the scan still runs.
                    for (int r = 0; r < ROWS; r++) begin
                        if (wr_row == ROW_W'(r)) begin
                            rows_d[r] = rows_q[r] | wr_mask;
                        end
                    end
                    scan_row_d = LAST_ROW;
                    count_d    = '0;
                    state_d    = S_SCAN;
                end
            end

            S_SCAN: begin
                if (row_full[scan_row_q]) begin
                    state_d = S_SHIFT;
                end else if (scan_row_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    scan_row_d = scan_row_q - 1'b1;
                end
            end

            S_SHIFT: begin
                for (int r = 0; r < ROWS; r++) begin
                    if (r == 0) begin
                        rows_d[r] = '0;
                    end else if (ROW_W'(r) <= scan_row_q) begin
                        rows_d[r] = rows_q[r-1];
                    end
                end
                count_d = count_q + 1'b1;
                // The row sliding into scan_row is re-checked here, so each removed row costs one cycle.
                if (above_full[scan_row_q]) begin
                    state_d = S_SHIFT;
                end else if (scan_row_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    scan_row_d = scan_row_q - 1'b1;
                    state_d    = S_SCAN;
                end
            end

            S_DONE: begin
                lines_total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
                state_d       = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            scan_row_q    <= LAST_ROW;
            count_q       <= '0;
            lines_total_q <= '0;
            // NOTE: the array is flops, not RAM: every cell is on grid at once and must reset to empty.
            for (int r = 0; r < ROWS; r++) begin
                rows_q[r] <= '0;
            end
        end else begin
            state_q       <= state_d;
            scan_row_q    <= scan_row_d;
            count_q       <= count_d;
            lines_total_q <= lines_total_d;
            rows_q        <= rows_d;
        end
    end

    always_comb begin
        array_flat = '0;
        for (int r = 0; r < ROWS; r++) begin
            array_flat[(ROWS-1-r)*COLS +: COLS] = rows_q[r];
        end
    end

`ifdef PLAYFIELD_SHADOW_EN
    logic [ROWS*COLS-1:0] grid_q;

    // Only refreshed between frames while no line clear is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_q <= '0;
        end else if (vblank && (state_q == S_IDLE)) begin
            grid_q <= array_flat;
        end
    end

    assign grid = grid_q;
`else
    logic unused_vblank;

    assign unused_vblank = vblank;
    assign grid          = array_flat;
`endif

endmodule

// File: tb/tb_playfield_buffer.sv
// Self-checking bench for playfield_buffer: directed vector table, multi-cycle corner cases,
// and randomized writes scored against a row-filtering reference model.
module tb_playfield_buffer;

    localparam int ROWS = 20;
    localparam int COLS = 12;
    localparam int W    = ROWS * COLS;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_row;
    logic [11:0]   wr_mask;
    logic          board_clear;
    logic          vblank;
    logic [W-1:0]  grid;
    logic          done;
    logic [4:0]    lines_cleared;
    logic [15:0]   lines_total;

    int total;
    int bad;

    logic [11:0] mrow [ROWS];
    int          mtotal;

    typedef struct {
        bit          clr;
        logic [4:0]  row;
        logic [11:0] mask;
        int          exp_k;
    } vec_t;

    vec_t vecs [7];

    playfield_buffer #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_row        (wr_row),
        .wr_mask       (wr_mask),
        .board_clear   (board_clear),
        .vblank        (vblank),
        .grid          (grid),
        .done          (done),
        .lines_cleared (lines_cleared),
        .lines_total   (lines_total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) mrow[r] = 12'h000;
        mtotal = 0;
    endtask

    // Set the cells, then drop every full row and let the rest fall, padding empty rows on top.
    task automatic model_write(input logic [4:0] row, input logic [11:0] mask, output int k);
        logic [11:0] keep [$];
        if (row < 5'd20) mrow[row] = mrow[row] | mask;
        k = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (&mrow[r]) k++;
            else keep.push_back(mrow[r]);
        end
        for (int r = ROWS - 1; r >= 0; r--) begin
            mrow[r] = (keep.size() > 0) ? keep.pop_front() : 12'h000;
        end
        mtotal = (mtotal + k > 65535) ? 65535 : mtotal + k;
    endtask

    function automatic logic [W-1:0] model_grid();
        logic [W-1:0] g;
        g = '0;
        for (int r = 0; r < ROWS; r++) g[(ROWS-1-r)*COLS +: COLS] = mrow[r];
        return g;
    endfunction

    // Called at negedge n0 after the accept edge; done is due at negedge 21+K.
    task automatic finish_op(input string tag, input int kk, input int n0, input bit chk_grid);
        bit         seen;
        int         lat;
        logic [4:0] lc;
        seen = 1'b0;
        lat  = 0;
        lc   = 5'd0;
        check({tag, "_busy"}, W'(wr_ready), W'(1'b0));
        for (int n = n0; n <= n0 + 60 && !seen; n++) begin
            if (done) begin
                seen = 1'b1;
                lat  = n;
                lc   = lines_cleared;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_latency"}, W'(lat), W'(21 + kk));
        check({tag, "_lines_cleared"}, W'(lc), W'(kk));
        @(negedge clk);
        check({tag, "_done_pulse"}, W'(done), W'(1'b0));
        @(negedge clk);
        check({tag, "_lines_total"}, W'(lines_total), W'(mtotal));
        if (chk_grid) check({tag, "_grid"}, grid, model_grid());
    endtask

    task automatic run_write(input logic [4:0] row, input logic [11:0] mask, input bit with_clear,
                             input bit backdoor, input bit chk_grid, input int exp_k, input string tag);
        int k;
        int kk;
        @(negedge clk);
        if (backdoor) begin
            for (int r = 0; r < ROWS; r++) dut.rows_q[r] = mrow[r];
            dut.lines_total_q = 16'(mtotal);
        end
        wr_valid = 1'b1;
        wr_row   = row;
        wr_mask  = mask;
        if (with_clear) begin
            board_clear = 1'b1;
            #1 check({tag, "_ready_blocked"}, W'(wr_ready), W'(1'b0));
            @(posedge clk);
            model_reset();
            @(negedge clk);
            board_clear = 1'b0;
            #1 check({tag, "_clr_total"}, W'(lines_total), W'(16'h0000));
            check({tag, "_clr_no_accept"}, W'(done), W'(1'b0));
`ifndef PLAYFIELD_SHADOW_EN
            check({tag, "_clr_grid"}, grid, W'(0));
`endif
        end
        #1 check({tag, "_ready"}, W'(wr_ready), W'(1'b1));
        @(posedge clk);
        model_write(row, mask, k);
        kk = (exp_k >= 0) ? exp_k : k;
        @(negedge clk);
        wr_valid = 1'b0;
        finish_op(tag, kk, 1, chk_grid);
    endtask

    initial begin
        int           k;
        int           seen;
        logic [W-1:0] old_grid;

        total       = 0;
        bad         = 0;
        wr_valid    = 1'b0;
        wr_row      = 5'd0;
        wr_mask     = 12'h000;
        board_clear = 1'b0;
        vblank      = 1'b1;
        rst_n       = 1'b1;
        model_reset();

        vecs[0] = '{1'b0, 5'd19, 12'h00F, 0};
        vecs[1] = '{1'b0, 5'd19, 12'h7F0, 0};
        vecs[2] = '{1'b0, 5'd18, 12'h5A5, 0};
        vecs[3] = '{1'b0, 5'd19, 12'h800, 1};
        vecs[4] = '{1'b0, 5'd25, 12'hFFF, 0};
        vecs[5] = '{1'b1, 5'd0,  12'h001, 0};
        vecs[6] = '{1'b0, 5'd0,  12'hFFE, 1};

        // Reset acts before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst_grid", grid, W'(0));
        check("rst_done", W'(done), W'(1'b0));
        check("rst_lines_cleared", W'(lines_cleared), W'(5'd0));
        check("rst_lines_total", W'(lines_total), W'(16'h0000));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release_ready", W'(wr_ready), W'(1'b1));

        for (int i = 0; i < 7; i++) begin
            run_write(vecs[i].row, vecs[i].mask, vecs[i].clr, 1'b0, 1'b1, vecs[i].exp_k,
                      $sformatf("vec%0d", i));
        end

        // Four stacked full rows; preloaded because a write can only complete one row.
        for (int r = 0; r < ROWS; r++) mrow[r] = 12'h000;
        mrow[12] = 12'h111; mrow[13] = 12'h222; mrow[14] = 12'h333; mrow[15] = 12'h444;
        mrow[16] = 12'hFFF; mrow[17] = 12'hFFF; mrow[18] = 12'hFFF; mrow[19] = 12'hFFE;
        run_write(5'd19, 12'h001, 1'b0, 1'b1, 1'b1, 4, "four_lines");

        // Same clear starting one below saturation.
        for (int r = 0; r < ROWS; r++) mrow[r] = 12'h000;
        mrow[12] = 12'h0F0; mrow[13] = 12'h00F; mrow[14] = 12'hF00; mrow[15] = 12'h801;
        mrow[16] = 12'hFFF; mrow[17] = 12'hFFF; mrow[18] = 12'hFFF; mrow[19] = 12'hFFE;
        mtotal = 16'hFFFE;
        run_write(5'd19, 12'h001, 1'b0, 1'b1, 1'b1, 4, "saturate");
        check("saturate_value", W'(lines_total), W'(16'hFFFF));

        // board_clear while busy must be ignored.
        @(negedge clk);
        wr_valid = 1'b1; wr_row = 5'd3; wr_mask = 12'h00F;
        @(posedge clk);
        model_write(5'd3, 12'h00F, k);
        @(negedge clk);
        wr_valid    = 1'b0;
        board_clear = 1'b1;
        @(negedge clk);
        board_clear = 1'b0;
        finish_op("clr_ignored", k, 2, 1'b1);

        // Reset mid-scan abandons the operation.
        @(negedge clk);
        wr_valid = 1'b1; wr_row = 5'd10; wr_mask = 12'h0F0;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midscan_grid", grid, W'(0));
        check("midscan_done", W'(done), W'(1'b0));
        check("midscan_total", W'(lines_total), W'(16'h0000));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midscan_ready", W'(wr_ready), W'(1'b1));
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("midscan_no_done", W'(seen), W'(0));

`ifdef PLAYFIELD_SHADOW_EN
        old_grid = model_grid();
        @(negedge clk);
        vblank = 1'b0;
        run_write(5'd7, 12'h3C0, 1'b0, 1'b0, 1'b0, -1, "shadow");
        check("shadow_hold", grid, old_grid);
        @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        check("shadow_load", grid, model_grid());
`else
        @(negedge clk);
        vblank   = 1'b0;
        wr_valid = 1'b1; wr_row = 5'd7; wr_mask = 12'h3C0;
        @(posedge clk);
        model_write(5'd7, 12'h3C0, k);
        old_grid = model_grid();
        @(negedge clk);
        wr_valid = 1'b0;
        check("scan_visible", grid, old_grid);
        finish_op("scan_visible", k, 1, 1'b1);
        vblank = 1'b1;
`endif

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  row;
            logic [11:0] mask;
            bit          clr;
            bit          bd;
            row = 5'($urandom_range(0, 23));
            clr = ($urandom_range(0, 7) == 0);
            bd  = !clr && ($urandom_range(0, 3) == 0);
            if (bd) begin
                for (int j = 0; j < 3; j++) begin
                    if ($urandom_range(0, 1) == 1) mrow[$urandom_range(0, 19)] = 12'hFFF;
                end
            end
            if (row < 5'd20 && $urandom_range(0, 2) == 0) mask = ~mrow[row] | 12'($urandom_range(0, 15));
            else mask = 12'($urandom);
            run_write(row, mask, clr, bd, 1'b1, -1, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
